ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit: the requesting end of the instruction RAM read port. Keeps the PC, drives the RAM word address every cycle, and captures the read data, which returns one cycle after the address. Delivers (pc, instruction) pairs to decode over a valid/ready handshake. Accepts branch/jump redirects from execute. Sits between `iram` and the decode stage.

## Interface
- `RESET_PC`, default 0: byte address fetched first after reset. Bits [1:0] are ignored.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `imem_addr`  out  ADDR_LEN: word index to the instruction RAM, equal to pc[ADDR_LEN+1:2].
- `imem_data`  in  XLEN: RAM read data for the address driven in the previous cycle.
- `redirect_valid`  in  1: redirect request.
- `redirect_pc`  in  XLEN: redirect target byte address; bits [1:0] are forced to 0.
- `out_valid`  out  1: an instruction is available to decode.
- `out_ready`  in  1: decode accepts the instruction.
- `out_pc`  out  XLEN: byte address of `out_instr`.
- `out_instr`  out  XLEN: instruction word.

## Operation
- State:
  - `fetch_pc`: next address to issue.
  - `inflight`: 1 bit, with its pc register `inflight_pc`.
  - 2-entry output FIFO of {pc, instr}.
- Issue condition in a cycle: `count + inflight - pop < 2`, where pop = out_valid & out_ready.
- On issue:
  - `imem_addr` = index of `fetch_pc`.
  - `inflight` is set with `inflight_pc` = `fetch_pc`.
  - `fetch_pc` += 4, modulo 2^XLEN. The RAM index wraps modulo LINES.
- Without issue: `imem_addr` holds its value and `fetch_pc` is unchanged.
- Capture: when `inflight` = 1, {`inflight_pc`, `imem_data`} is pushed into the FIFO at the clock edge. The credit rule guarantees the FIFO never overflows.
- FIFO: output comes from the head register. `out_valid` = (count != 0). A pop and a push in the same cycle are both allowed.
- Redirect (`redirect_valid` = 1) has priority over everything else:
  - FIFO is flushed to count 0.
  - The old inflight data is discarded.
  - `imem_addr` is driven combinationally with the index of `redirect_pc` in the same cycle. That address is issued unconditionally: `inflight` = 1, `inflight_pc` = target.
  - `fetch_pc` = target + 4.
  - A handshake that coincides with the redirect is void. Decode owns the redirect and discards that instruction itself.
- Reset:
  - `out_valid` = 0, `out_pc` = 0, `out_instr` = 0, count = 0, `inflight` = 0.
  - `fetch_pc` = RESET_PC, and `imem_addr` = index of RESET_PC.
  - An assertion mid-stream discards all buffered and inflight data at the next edge.

## Timing
- Cycle R is the first cycle with `rst` low. R issues RESET_PC; R+1 issues RESET_PC+4.
- At R+2, `out_valid` = 1 and `out_pc` = RESET_PC.
- With `out_ready` held at 1, throughput is one instruction per cycle, with consecutive pcs.
- Redirect asserted in cycle t: `out_valid` = 0 in t+1, and the target appears on the output in t+2. Penalty is 2 cycles.
- Backpressure: with `out_ready` = 0, the FIFO fills to 2 and issue stops. Once `out_ready` rises, output resumes in the same cycle with no lost or duplicated pc.
- No combinational path from `out_ready` to `out_valid`/`out_pc`/`out_instr`. The only combinational path to `imem_addr` is from `redirect_*` and the issue condition.

## Structure
- From `cpu_config`: XLEN, ADDR_LEN, LINES.
- `cpu_types` gains `fetch_packet_t` {pc: XLEN, instr: XLEN}, used for the FIFO and the decode interface.
- Sub-module `ifetch_fifo`: 2-entry FIFO of `fetch_packet_t` with synchronous flush. Ports: push, pop, flush, count, head.
- The top level holds the PC/inflight/credit logic. Target size is about 150–200 lines in total.

## Test plan
- Reset and stream:
  - Stimulus: RAM preloaded with word i = 0x1000+i, RESET_PC = 0, `out_ready` = 1.
  - Response: first `out_valid` at R+2 with pc 0x0 and instr 0x1000, then pc 0x4/0x1001, 0x8/0x1002 on consecutive cycles.
- Backpressure:
  - Stimulus: `out_ready` = 0 for 5 cycles from R+2, then 1.
  - Response: `out_pc` holds 0x0, count saturates at 2, `imem_addr` stops advancing; after release, pcs 0x0, 0x4, 0x8 follow with no gaps or duplicates.
- Redirect:
  - Stimulus: `redirect_valid` with `redirect_pc` = 0x40 while streaming.
  - Response: `imem_addr` = 0x10 in that cycle, `out_valid` = 0 the next cycle, then pc 0x40/instr 0x1010, then 0x44.
- Redirect plus handshake, and misaligned target:
  - Stimulus: redirect to 0x43 while `out_valid` & `out_ready`.
  - Response: output resumes at 0x40; the stale pc never appears again.
- Wrap-around:
  - Stimulus: redirect to (LINES-1)*4.
  - Response: that word is delivered, then pc = LINES*4 with instr read from index 0.
- Mid-stream reset:
  - Stimulus: `rst` pulsed for 1 cycle with 2 entries buffered.
  - Response: `out_valid` = 0 the next cycle, and the fetch sequence restarts from RESET_PC with R+2 latency.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared sizing and the fetch packet carried from fetch to decode.
package ifetch_pkg;
  localparam int XLEN     = 32;
  localparam int ADDR_LEN = 6;
  localparam int LINES    = 1 << ADDR_LEN;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_packet_t;
endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry output buffer of fetch packets; head is always entry 0, flush empties it.
module ifetch_fifo
  import ifetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_packet_t din,
  output logic [1:0]    count,
  output fetch_packet_t head
);
  fetch_packet_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0]    count_q, count_d;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            e0_d    = din;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            e0_d = din;
          end else if (push) begin
            e1_d    = din;
            count_d = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        default: begin
          // A push into a full buffer cannot happen: the issue credit prevents it.
          if (pop) begin
            e0_d    = e1_q;
            count_d = 2'd1;
            if (push) begin
              e1_d    = din;
              count_d = 2'd2;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = e0_q;
endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC, RAM address issue with credit-based flow control, redirects,
// and a two-entry buffer toward decode.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_LEN-1:0] imem_addr,
  input  logic [XLEN-1:0]     imem_data,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_instr
);
  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
  logic                inflight_q, inflight_d;
  logic [XLEN-1:0]     inflight_pc_q, inflight_pc_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0]     target;
  logic [1:0]          fifo_count;
  logic [1:0]          credit_used;
  logic                pop, push, issue;
  fetch_packet_t       head, push_pkt;

  assign target = redirect_pc & ~XLEN'(3);
  assign pop    = out_valid & out_ready & ~redirect_valid;
  assign push   = inflight_q & ~redirect_valid;

  // Slots already claimed after this cycle: buffered plus returning, minus the one leaving.
  assign credit_used = fifo_count + {1'b0, inflight_q} - {1'b0, pop};
  assign issue       = (credit_used < 2'd2);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    addr_d        = addr_q;
    if (redirect_valid) begin
      addr_d        = target[ADDR_LEN+1:2];
      inflight_d    = 1'b1;
      inflight_pc_d = target;
      fetch_pc_d    = target + XLEN'(4);
    end else if (issue) begin
      addr_d        = fetch_pc_q[ADDR_LEN+1:2];
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + XLEN'(4);
    end
  end

  assign imem_addr = addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC_ALIGNED;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      addr_q        <= RESET_PC_ALIGNED[ADDR_LEN+1:2];
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      addr_q        <= addr_d;
    end
  end

  assign push_pkt.pc    = inflight_pc_q;
  assign push_pkt.instr = imem_data;

  ifetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_pkt),
    .count (fifo_count),
    .head  (head)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios then random ready/redirect/reset traffic,
// all checked against a stream-level model of the expected pc sequence.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0;

  logic                clk = 1'b0;
  logic                rst;
  logic [ADDR_LEN-1:0] imem_addr;
  logic [XLEN-1:0]     imem_data;
  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [XLEN-1:0]     out_instr;

  logic [XLEN-1:0] mem [LINES];
  logic [XLEN-1:0] exp_q [$];
  logic [XLEN-1:0] exp_pc;
  logic [XLEN-1:0] hold_addr;
  int              age;
  bit              ev_rst;
  int              n_cmp = 0;
  int              n_err = 0;

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];

  ifetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_instr(input logic [XLEN-1:0] pc);
    return mem[(pc >> 2) % LINES];
  endfunction

  // Sample mid-cycle and apply the stream model: after a restart point the output
  // is an unbroken run pc, pc+4, ... valid from two cycles later onward.
  task automatic smp();
    @(negedge clk);
    if (!rst) begin
      if ((ev_rst && age == 0) || age == 1)
        chk("restart_bubble_valid", {31'b0, out_valid}, 32'd0);
      if (ev_rst && (age == 0 || age == 1)) begin
        chk("reset_out_pc", out_pc, 32'd0);
        chk("reset_out_instr", out_instr, 32'd0);
      end
      if (age >= 2)
        chk("steady_valid", {31'b0, out_valid}, 32'd1);
      if (out_valid) begin
        chk("model_pc", out_pc, exp_pc);
        chk("model_instr", out_instr, ref_instr(exp_pc));
      end
      if (redirect_valid) begin
        chk("redirect_addr", {{(XLEN-ADDR_LEN){1'b0}}, imem_addr}, (redirect_pc >> 2) % LINES);
        exp_pc = (redirect_pc >> 2) << 2;
      end else if (out_valid && out_ready) begin
        exp_pc = exp_pc + 4;
      end
    end
    if (rst) begin
      age    = -1;
      ev_rst = 1'b1;
      exp_pc = (RESET_PC >> 2) << 2;
    end else if (redirect_valid) begin
      age    = 0;
      ev_rst = 1'b0;
    end
    age++;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      smp();
      nxt();
    end
  endtask

  initial begin
    for (int i = 0; i < LINES; i++) mem[i] = 32'h1000 + i;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    age            = 0;
    ev_rst         = 1'b1;
    exp_pc         = RESET_PC;
    idle(3);

    // reset and stream
    rst = 1'b0;
    smp(); chk("R_addr", {26'b0, imem_addr}, 32'd0); nxt();
    smp(); chk("R1_addr", {26'b0, imem_addr}, 32'd1); nxt();
    smp(); chk("R2_valid", {31'b0, out_valid}, 32'd1);
    chk("R2_pc", out_pc, 32'h0); chk("R2_instr", out_instr, 32'h1000); nxt();
    smp(); chk("R3_pc", out_pc, 32'h4); chk("R3_instr", out_instr, 32'h1001); nxt();
    smp(); chk("R4_pc", out_pc, 32'h8); chk("R4_instr", out_instr, 32'h1002); nxt();

    // backpressure from R+2
    rst = 1'b1; idle(1); rst = 1'b0;
    idle(2);
    out_ready = 1'b0;
    smp(); hold_addr = {26'b0, imem_addr}; nxt();
    for (int i = 1; i < 5; i++) begin
      smp();
      chk("bp_hold_pc", out_pc, 32'h0);
      chk("bp_addr_stalled", {26'b0, imem_addr}, hold_addr);
      nxt();
    end
    chk("bp_count_full", {30'b0, dut.fifo_count}, 32'd2);
    out_ready = 1'b1;
    exp_q = {32'h0, 32'h4, 32'h8};
    while (exp_q.size() > 0) begin
      smp(); chk("bp_release_pc", out_pc, exp_q.pop_front()); nxt();
    end

    // mid-stream reset with two entries buffered
    out_ready = 1'b0;
    idle(2);
    smp(); chk("mr_count_full", {30'b0, dut.fifo_count}, 32'd2); nxt();
    rst = 1'b1; out_ready = 1'b1; idle(1); rst = 1'b0;
    smp(); chk("mr_valid_low", {31'b0, out_valid}, 32'd0); nxt();
    idle(1);
    smp(); chk("mr_restart_pc", out_pc, RESET_PC); nxt();
    idle(2);

    // redirect while streaming
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    smp(); chk("rd_addr", {26'b0, imem_addr}, 32'h10); nxt();
    redirect_valid = 1'b0;
    smp(); chk("rd_bubble", {31'b0, out_valid}, 32'd0); nxt();
    smp(); chk("rd_pc", out_pc, 32'h40); chk("rd_instr", out_instr, 32'h1010); nxt();
    smp(); chk("rd_pc_next", out_pc, 32'h44); nxt();

    // redirect coinciding with a handshake, misaligned target
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    smp(); chk("rh_handshake", {31'b0, out_valid & out_ready}, 32'd1); nxt();
    redirect_valid = 1'b0;
    idle(1);
    smp(); chk("rh_pc", out_pc, 32'h40); nxt();
    smp(); chk("rh_pc_next", out_pc, 32'h44); nxt();

    // wrap-around of the RAM index
    redirect_valid = 1'b1; redirect_pc = (LINES - 1) * 4;
    smp(); chk("wr_addr", {26'b0, imem_addr}, LINES - 1); nxt();
    redirect_valid = 1'b0;
    idle(1);
    smp(); chk("wr_last_pc", out_pc, (LINES - 1) * 4); chk("wr_last_instr", out_instr, 32'h1000 + LINES - 1); nxt();
    smp(); chk("wr_wrap_pc", out_pc, LINES * 4); chk("wr_wrap_instr", out_instr, 32'h1000); nxt();

    // random traffic
    for (int i = 0; i < 800; i++) begin
      int r;
      r              = $urandom_range(0, 63);
      rst            = (r == 0);
      redirect_valid = !rst && (r < 5);
      redirect_pc    = $urandom;
      out_ready      = ($urandom_range(0, 3) != 0);
      smp();
      nxt();
    end
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
